// File: rtl/fp_addsub_seq_if.sv
// Handshake bundle between the FPU op dispatcher (master) and fp_addsub_seq (slave).
// Operand/result words are 1+EXP_W+MAN_W bits wide.
interface fp_addsub_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   exc;

  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
    input  in_ready, out_valid, result, exc
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
    output in_ready, out_valid, result, exc
  );
endinterface

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 add/subtract, round-to-nearest-even, fixed latency.
// Define FP_ADDSUB_FTZ_EN to flush subnormal inputs and results to signed zero.
//
// state | meaning
// IDLE  | ready for operands, captures A and sign-adjusted B
// ALIGN | special detection, big/small ordering, small operand right shift
// ADD   | integer add or subtract of aligned significands
// NORM  | carry shift or leading-zero shift, subnormal detection
// ROUND | RNE rounding, overflow, flags, special override
// DONE  | result presented until out_ready
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic            CLK,
  input logic            RSTn,
  fp_addsub_seq_if.slave bus
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int DW = MAN_W + 4;

  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0]     QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [W-1:0]      result_q, result_d;
  logic [3:0]        exc_q, exc_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic              sign_q, sign_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [DW-1:0]     mbig_q, mbig_d;
  logic [DW-1:0]     msml_q, msml_d;
  logic              eff_sub_q, eff_sub_d;
  logic              spec_q, spec_d;
  logic [W-1:0]      spec_res_q, spec_res_d;
  logic [3:0]        spec_exc_q, spec_exc_d;
  logic [DW:0]       sum_q, sum_d;
  logic [DW-1:0]     nman_q, nman_d;
  logic [EXP_W-1:0]  nexp_q, nexp_d;
  logic              zero_q, zero_d;

  function automatic logic [W-1:0] flush_in(input logic [W-1:0] v);
`ifdef FP_ADDSUB_FTZ_EN
    flush_in = (v[W-2:MAN_W] == '0) ? {v[W-1], {(W-1){1'b0}}} : v;
`else
    flush_in = v;
`endif
  endfunction

  // ---------------- ALIGN datapath ----------------
  logic [EXP_W-1:0] ea, eb, e_big, e_sml, e_big_eff, e_sml_eff, d_sh;
  logic [MAN_W-1:0] fa, fb, f_big, f_sml;
  logic             nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, a_big, s_big;
  logic [DW-2:0]    sml_ext, sml_sh;
  logic             sml_lost;
  logic             al_spec;
  logic [W-1:0]     al_spec_res;
  logic [3:0]       al_spec_exc;

  assign ea     = a_q[W-2:MAN_W];
  assign eb     = b_q[W-2:MAN_W];
  assign fa     = a_q[MAN_W-1:0];
  assign fb     = b_q[MAN_W-1:0];
  assign nan_a  = (ea == EMAX) && (fa != '0);
  assign nan_b  = (eb == EMAX) && (fb != '0);
  assign snan_a = nan_a && !fa[MAN_W-1];
  assign snan_b = nan_b && !fb[MAN_W-1];
  assign inf_a  = (ea == EMAX) && (fa == '0);
  assign inf_b  = (eb == EMAX) && (fb == '0);
  assign a_big  = a_q[W-2:0] >= b_q[W-2:0];

  always_comb begin
    e_big = a_big ? ea : eb;
    f_big = a_big ? fa : fb;
    s_big = a_big ? a_q[W-1] : b_q[W-1];
    e_sml = a_big ? eb : ea;
    f_sml = a_big ? fb : fa;
    e_big_eff = (e_big == '0) ? EXP_W'(1) : e_big;
    e_sml_eff = (e_sml == '0) ? EXP_W'(1) : e_sml;
    d_sh      = e_big_eff - e_sml_eff;
    sml_ext   = {(e_sml != '0), f_sml, 2'b00};
    // Shifts wider than the datapath naturally leave only the sticky bit.
    sml_sh    = sml_ext >> d_sh;
    sml_lost  = |(sml_ext & ~({(DW-1){1'b1}} << d_sh));
  end

  always_comb begin
    al_spec     = nan_a | nan_b | inf_a | inf_b;
    al_spec_res = b_q;
    al_spec_exc = 4'b0000;
    if (nan_a || nan_b) begin
      al_spec_res = QNAN;
      al_spec_exc = {snan_a | snan_b, 3'b000};
    end else if (inf_a && inf_b && (a_q[W-1] != b_q[W-1])) begin
      al_spec_res = QNAN;
      al_spec_exc = 4'b1000;
    end else if (inf_a) begin
      al_spec_res = a_q;
    end
  end

  // ---------------- NORM datapath ----------------
  logic [DW-1:0]    n_man0, n_man;
  logic [EXP_W-1:0] n_exp;
  logic [31:0]      lzc, exp_m1, n_sh;
  logic             n_zero;

  always_comb begin
    n_man0 = sum_q[DW-1:0];
    lzc    = 32'(DW);
    for (int i = 0; i < DW; i++) begin
      if (n_man0[i]) lzc = 32'(DW - 1 - i);
    end
    exp_m1 = 32'(exp_q) - 32'd1;
    n_sh   = (lzc < exp_m1) ? lzc : exp_m1;
    n_zero = !sum_q[DW] && (n_man0 == '0);
    if (sum_q[DW]) begin
      n_man = {sum_q[DW:2], sum_q[1] | sum_q[0]};
      n_exp = exp_q + EXP_W'(1);
    end else begin
      n_man = n_man0 << n_sh;
      n_exp = exp_q - n_sh[EXP_W-1:0];
      // Shift clamped at the minimum exponent: subnormal, exp field 0.
      if (!n_man[DW-1]) n_exp = '0;
    end
  end

  // ---------------- ROUND datapath ----------------
  logic [MAN_W:0]   r_mant;
  logic [MAN_W+1:0] r_sum;
  logic [MAN_W-1:0] r_frac;
  logic [EXP_W:0]   r_exp;
  logic             r_g, r_r, r_s, r_up, r_inexact;
  logic [W-1:0]     r_res;
  logic [3:0]       r_exc;

  always_comb begin
    r_mant    = nman_q[DW-1:3];
    r_g       = nman_q[2];
    r_r       = nman_q[1];
    r_s       = nman_q[0];
    r_up      = r_g & (r_r | r_s | nman_q[3]);
    r_inexact = r_g | r_r | r_s;
    r_sum     = {1'b0, r_mant} + {{(MAN_W+1){1'b0}}, r_up};
    r_exp     = {1'b0, nexp_q};
    r_frac    = r_sum[MAN_W-1:0];
    if (r_sum[MAN_W+1]) begin
      r_exp  = r_exp + 1'b1;
      r_frac = '0;
    end else if ((nexp_q == '0) && r_sum[MAN_W]) begin
      r_exp = (EXP_W+1)'(1);
    end

    if (spec_q) begin
      r_res = spec_res_q;
      r_exc = spec_exc_q;
    end else if (zero_q) begin
      r_res = {~eff_sub_q & sign_q, {(W-1){1'b0}}};
      r_exc = 4'b0000;
    end else if (r_exp >= {1'b0, EMAX}) begin
      r_res = {sign_q, EMAX, {MAN_W{1'b0}}};
      r_exc = 4'b0101;
    end
`ifdef FP_ADDSUB_FTZ_EN
    else if (r_exp == '0) begin
      r_res = {sign_q, {(W-1){1'b0}}};
      r_exc = 4'b0011;
    end
`endif
    else begin
      r_res = {sign_q, r_exp[EXP_W-1:0], r_frac};
      r_exc = {2'b00, (r_exp == '0) && r_inexact, r_inexact};
    end
  end

  // ---------------- FSM / next state ----------------
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    exc_d       = exc_q;
    a_d         = a_q;
    b_d         = b_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mbig_d      = mbig_q;
    msml_d      = msml_q;
    eff_sub_d   = eff_sub_q;
    spec_d      = spec_q;
    spec_res_d  = spec_res_q;
    spec_exc_d  = spec_exc_q;
    sum_d       = sum_q;
    nman_d      = nman_q;
    nexp_d      = nexp_q;
    zero_d      = zero_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d     = flush_in(bus.op_a);
          b_d     = flush_in(bus.op_b ^ {bus.sub, {(W-1){1'b0}}});
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        sign_d     = s_big;
        exp_d      = e_big_eff;
        mbig_d     = {(e_big != '0), f_big, 3'b000};
        msml_d     = {sml_sh, sml_lost};
        eff_sub_d  = a_q[W-1] ^ b_q[W-1];
        spec_d     = al_spec;
        spec_res_d = al_spec_res;
        spec_exc_d = al_spec_exc;
        state_d    = S_ADD;
      end
      S_ADD: begin
        sum_d   = eff_sub_q ? ({1'b0, mbig_q} - {1'b0, msml_q})
                            : ({1'b0, mbig_q} + {1'b0, msml_q});
        state_d = S_NORM;
      end
      S_NORM: begin
        nman_d  = n_man;
        nexp_d  = n_exp;
        zero_d  = n_zero;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        result_d    = r_res;
        exc_d       = r_exc;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      exc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mbig_q      <= '0;
      msml_q      <= '0;
      eff_sub_q   <= 1'b0;
      spec_q      <= 1'b0;
      spec_res_q  <= '0;
      spec_exc_q  <= '0;
      sum_q       <= '0;
      nman_q      <= '0;
      nexp_q      <= '0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      exc_q       <= exc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mbig_q      <= mbig_d;
      msml_q      <= msml_d;
      eff_sub_q   <= eff_sub_d;
      spec_q      <= spec_d;
      spec_res_q  <= spec_res_d;
      spec_exc_q  <= spec_exc_d;
      sum_q       <= sum_d;
      nman_q      <= nman_d;
      nexp_q      <= nexp_d;
      zero_q      <= zero_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.exc       = exc_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq (binary32): directed vectors, backpressure,
// mid-operation reset, and random operands checked against an exact-arithmetic model.
module tb_fp_addsub_seq;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int LAT   = 5;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fp_addsub_seq_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();
  fp_addsub_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (.CLK(clk), .RSTn(rstn), .bus(bus));

  typedef struct { logic [31:0] res; logic [3:0] exc; int acc; } exp_t;
  typedef struct { logic [31:0] a; logic [31:0] b; logic s; logic [31:0] res; logic [3:0] exc; } vec_t;

  exp_t sb[$];
  vec_t dir[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   force_stall = 1'b0;
  bit   seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Exact reference: operands as integers in units of the smallest subnormal, then RNE.
  function automatic logic [35:0] model(input logic [31:0] a_in, input logic [31:0] b_in, input logic s);
    logic [31:0]  a, b;
    logic [299:0] ma, mb, mr, q, rem, half;
    logic         sr, inx;
    int           p, sh, ex;
    a = a_in;
    b = b_in ^ {s, 31'b0};
`ifdef FP_ADDSUB_FTZ_EN
    if (a[30:23] == 8'h00) a[22:0] = '0;
    if (b[30:23] == 8'h00) b[22:0] = '0;
`endif
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
      return {32'h7FC00000,
              ((a[30:23] == 8'hFF && a[22:0] != 0 && !a[22]) ||
               (b[30:23] == 8'hFF && b[22:0] != 0 && !b[22])), 3'b000};
    if (a[30:0] == 31'h7F800000 && b[30:0] == 31'h7F800000)
      return (a[31] != b[31]) ? {32'h7FC00000, 4'b1000} : {a, 4'b0000};
    if (a[30:0] == 31'h7F800000) return {a, 4'b0000};
    if (b[30:0] == 31'h7F800000) return {b, 4'b0000};
    ma = 300'({a[30:23] != 0, a[22:0]}) << ((a[30:23] == 0) ? 0 : int'(a[30:23]) - 1);
    mb = 300'({b[30:23] != 0, b[22:0]}) << ((b[30:23] == 0) ? 0 : int'(b[30:23]) - 1);
    if (a[31] == b[31]) begin mr = ma + mb; sr = a[31]; end
    else if (ma >= mb)  begin mr = ma - mb; sr = a[31]; end
    else                begin mr = mb - ma; sr = b[31]; end
    if (mr == 0) return {(a[31] == b[31]) ? a[31] : 1'b0, 31'b0, 4'b0000};
    p = -1;
    for (int i = 0; i < 300; i++) if (mr[i]) p = i;
    if (p <= 23) begin
`ifdef FP_ADDSUB_FTZ_EN
      if (p < 23) return {sr, 31'b0, 4'b0011};
`endif
      return {sr, (p == 23) ? 8'd1 : 8'd0, mr[22:0], 4'b0000};
    end
    sh   = p - 23;
    q    = mr >> sh;
    rem  = mr & ((300'd1 << sh) - 300'd1);
    half = 300'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 300'd1;
    if (q[24]) begin q = q >> 1; sh++; end
    ex  = sh + 1;
    inx = (rem != 0);
    if (ex >= 255) return {sr, 8'hFF, 23'b0, 4'b0101};
    return {sr, 8'(ex), q[22:0], 3'b000, inx};
  endfunction

  function automatic logic [31:0] rand_op(input logic [31:0] near);
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 15))
      0:       v = {v[31], 8'hFF, 23'b0};
      1:       v = {v[31], 8'hFF, v[22:0] | 23'h1};
      2:       v = {v[31], 31'b0};
      3, 4:    v[30:23] = 8'h00;
      5, 6, 7: v[30:23] = near[30:23] + 8'($urandom_range(0, 4)) - 8'd2;
      8:       v[30:23] = 8'hFE;
      9:       v = near ^ 32'($urandom_range(0, 7));
      default: ;
    endcase
    return v;
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input bit push, input logic [31:0] res, input logic [3:0] exc);
    int n;
    exp_t e;
    n = 0;
    while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.sub      = s;
    if (push) begin
      e.res = res; e.exc = exc; e.acc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !bus.in_ready) && n < 300) begin @(negedge clk); n++; end
    if (sb.size() != 0 || !bus.in_ready) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: owns out_ready, compares every presented result against the queue head.
  initial begin
    exp_t e;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin seen = 1'b0; continue; end
      bus.out_ready = force_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 64'(bus.result), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          if (!seen) begin
            chk("latency", 64'(cyc - sb[0].acc), 64'(LAT));
            seen = 1'b1;
          end
          if (bus.out_ready) begin
            e = sb.pop_front();
            chk("result", 64'(bus.result), 64'(e.res));
            chk("exc", 64'(bus.exc), 64'(e.exc));
            seen = 1'b0;
          end else begin
            chk("held_result", 64'(bus.result), 64'(sb[0].res));
            chk("held_exc", 64'(bus.exc), 64'(sb[0].exc));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d results pending", sb.size());
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    logic        s;
    logic [35:0] m;
    int          n;
    bus.in_valid = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.sub      = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_exc", 64'(bus.exc), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    dir.push_back(vec_t'{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000});
    dir.push_back(vec_t'{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000});
    dir.push_back(vec_t'{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000});
    dir.push_back(vec_t'{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001});
    dir.push_back(vec_t'{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001});
    dir.push_back(vec_t'{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101});
    dir.push_back(vec_t'{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000});
    dir.push_back(vec_t'{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000});
    dir.push_back(vec_t'{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000});
    dir.push_back(vec_t'{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000});
    dir.push_back(vec_t'{32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000, 4'b0000});
`ifdef FP_ADDSUB_FTZ_EN
    dir.push_back(vec_t'{32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 4'b0000});
`else
    dir.push_back(vec_t'{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0000});
`endif
    foreach (dir[i]) send(dir[i].a, dir[i].b, dir[i].s, 1'b1, dir[i].res, dir[i].exc);
    drain();

    // Backpressure: result held, no acceptance while stalled.
    force_stall = 1'b1;
    send(32'h3F800000, 32'h40000000, 1'b0, 1'b1, 32'h40400000, 4'b0000);
    n = 0;
    while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
    chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      bus.in_valid = 1'b1;
      bus.op_a     = $urandom;
      bus.op_b     = $urandom;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    force_stall  = 1'b0;
    drain();

    // Reset while the transaction sits in NORM: it must vanish.
    send(32'h40A00000, 32'h3FC00000, 1'b0, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_stale_out", 64'(bus.out_valid), 64'd0);
    end

    for (int i = 0; i < 300; i++) begin
      a = rand_op($urandom);
      b = rand_op(a);
      s = 1'($urandom_range(0, 1));
      m = model(a, b, s);
      send(a, b, s, 1'b1, m[35:4], m[3:0]);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
